// File: rtl/btn_ce_gen.sv
// btn_ce_gen: button conditioner for the counter stage.
// Synchronizes and debounces a raw push-button, then emits single-cycle
// clock-enable pulses: one per debounced press plus optional auto-repeat
// while the button stays held. The debounced level is exported as well.
module btn_ce_gen #(
  parameter int DIV          = 16,
  parameter int STABLE       = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic rep_en,
  output logic ce,
  output logic btn_level
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW   = $clog2(DIV + 1);
  localparam int SW   = $clog2(STABLE + 1);
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic [1:0]    sync_r;
  logic          btn_s;
  logic [DW-1:0] div_cnt_r;
  logic          tick_s;
  logic [SW-1:0] stable_cnt_r;
  logic          level_r;
  logic          level_prev_r;
  logic [RW-1:0] rep_cnt_r;
  logic          ce_r;
  state_t        state_r;

  assign btn_s     = sync_r[1];
  assign tick_s    = (div_cnt_r == DW'(DIV - 1));
  assign ce        = ce_r;
  assign btn_level = level_r;

  // Two-flop synchronizer bringing the asynchronous button into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_in};
    end
  end

  // Free-running sample-tick prescaler, 0..DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Debouncer: accept a new level only after STABLE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt_r <= '0;
      level_r      <= 1'b0;
    end else if (tick_s) begin
      if (btn_s != level_r) begin
        if (stable_cnt_r == SW'(STABLE - 1)) begin
          level_r      <= ~level_r;
          stable_cnt_r <= '0;
        end else begin
          stable_cnt_r <= stable_cnt_r + SW'(1);
        end
      end else begin
        stable_cnt_r <= '0;
      end
    end
  end

  // Previous debounced level, used for press-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_r <= 1'b0;
    end else begin
      level_prev_r <= level_r;
    end
  end

  // Press / auto-repeat FSM. The repeat counter reaches zero on a tick; the
  // pulse is issued on the following cycle, which is never a tick (DIV>=2),
  // so release (seen first) always wins over an expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rep_cnt_r <= '0;
      ce_r      <= 1'b0;
    end else begin
      ce_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (level_r && !level_prev_r) begin
            ce_r      <= 1'b1;
            rep_cnt_r <= RW'(REPEAT_DELAY);
            state_r   <= PRESSED;
          end else begin
            rep_cnt_r <= '0;
          end
        end
        PRESSED, REPEAT: begin
          if (!level_r) begin
            state_r   <= IDLE;
            rep_cnt_r <= '0;
          end else if (rep_cnt_r == '0) begin
            ce_r      <= rep_en;
            rep_cnt_r <= RW'(REPEAT_RATE);
            state_r   <= REPEAT;
          end else if (tick_s) begin
            rep_cnt_r <= rep_cnt_r - RW'(1);
          end else begin
            rep_cnt_r <= rep_cnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          rep_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_ce_gen.sv
// Self-checking bench for btn_ce_gen with DIV=4, STABLE=3, REPEAT_DELAY=4,
// REPEAT_RATE=2. Inputs change and outputs are sampled on the falling edge.
module tb_btn_ce_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic rep_en;
  logic ce;
  logic btn_level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  btn_ce_gen #(
    .DIV(4), .STABLE(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .rep_en(rep_en),
    .ce(ce), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic rep;
    int   cycles;
    int   exp_ce;
    logic exp_lvl;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n, dbl, lvl_at, t0, last_ce, first, fall, bad;
  logic prev;
  int ces[$];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 40,  0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 200, 1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 40,  0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 6,   0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 6,   0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 6,   0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 6,   0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 6,   0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 6,   0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 6,   0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6,   0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 60,  1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 40,  0, 1'b0};

    // Reset with button held: outputs low, then one press after 12+1 cycles.
    rst = 1'b1; btn_in = 1'b1; rep_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ce", ce, 0);
      check("rst_lvl", btn_level, 0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      check("post_rst_ce", ce, (i == 13));
      check("post_rst_lvl", btn_level, (i >= 12));
    end

    // Table-driven phases: release, clean press, bounce, press, release.
    for (int r = 0; r < 13; r++) begin
      btn_in = vecs[r].btn;
      rep_en = vecs[r].rep;
      n = 0; dbl = 0; prev = 1'b0;
      for (int c = 0; c < vecs[r].cycles; c++) begin
        step();
        if (ce) n++;
        if (ce && prev) dbl++;
        prev = ce;
      end
      check($sformatf("vec%0d_ce_count", r), n, vecs[r].exp_ce);
      check($sformatf("vec%0d_level", r), btn_level, vecs[r].exp_lvl);
      check($sformatf("vec%0d_ce_width", r), dbl, 0);
    end

    // Auto-repeat while held: press latency, then gaps of 16 and 8.
    btn_in = 1'b1; rep_en = 1'b1; lvl_at = 0; t0 = cyc;
    ces.delete();
    for (int i = 1; i <= 100; i++) begin
      step();
      if (btn_level && lvl_at == 0) lvl_at = i;
      if (ce) ces.push_back(i);
    end
    check("press_lat_in_range", (lvl_at >= 11 && lvl_at <= 14), 1);
    check("press_ce_lat", (ces.size() > 0) ? ces[0] : -1, lvl_at + 1);
    check("rep_count_min", (ces.size() >= 9), 1);
    check("rep_first_gap", (ces.size() > 1) ? ces[1] - ces[0] : 0, 16);
    for (int k = 2; k < ces.size(); k++) begin
      check("rep_gap", ces[k] - ces[k-1], 8);
    end
    last_ce = (ces.size() > 0) ? (t0 + ces[ces.size()-1]) : 0;

    // rep_en low mid-REPEAT: no pulses; resumption stays on the 8-cycle grid.
    rep_en = 1'b0; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ce) n++;
    end
    check("repoff_ce", n, 0);
    rep_en = 1'b1; first = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ce && first < 0) first = cyc;
    end
    check("rep_resume_seen", (first > 0), 1);
    check("rep_resume_grid", ((first - last_ce) % 8), 0);
    check("rep_resume_gap", (first - last_ce > 20), 1);

    // One-cycle reset mid-REPEAT with button held.
    rst = 1'b1;
    step();
    check("midrst_ce", ce, 0);
    check("midrst_lvl", btn_level, 0);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      check("midrst_ce_seq", ce, (i == 13 || i == 29 || i == 37));
      check("midrst_lvl_seq", btn_level, (i >= 12));
    end

    // Release while repeating: level falls within 14 cycles, no ce afterwards.
    btn_in = 1'b0; fall = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!btn_level && fall == 0) fall = i;
      if (ce && fall != 0) bad++;
    end
    check("rel_lat_in_range", (fall >= 1 && fall <= 14), 1);
    check("rel_no_ce", bad, 0);
    check("rel_lvl_end", btn_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
